imem_loader: RTL
================

Name: imem_loader

Overview:
- Fills the CPU instruction memory from a byte stream and controls CPU start-up.
- Sits between a host or boot byte source and the instruction-memory write port, and drives the CPU's active-low `rst_i`.
- On each load request it does three things in order:
  - zero-clears every instruction word;
  - packs incoming bytes little-endian into 32-bit words, written at sequential word addresses;
  - releases the CPU from reset once the last word has been written.

Parameters:
DEPTH, 256, number of 32-bit instruction words in instruction memory
ADDR_W, 8, word-address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  load request pulse; acted on in IDLE or DONE only
byte_valid_i  in  1  byte_data_i is valid
byte_data_i  in  8  stream byte
byte_last_i  in  1  marks the final byte of the program; qualified by byte_valid_i
byte_ready_o  out  1  loader can accept a byte this cycle
mem_we_o  out  1  instruction-memory write enable, one cycle per word
mem_addr_o  out  ADDR_W  word address of the write
mem_data_o  out  32  write data
cpu_rst_o  out  1  drives CPU rst_i; 0 holds the CPU in reset, 1 lets it run
busy_o  out  1  high in CLEAR, LOAD and FLUSH
done_o  out  1  high in DONE
word_count_o  out  ADDR_W+1  number of words written from the stream in the current load
overflow_o  out  1  sticky; high if stream bytes arrived after DEPTH words were written

Behaviour:
- Reset (rst_i=1 at an edge):
  - state goes to IDLE;
  - mem_we_o, byte_ready_o, busy_o, done_o, overflow_o, cpu_rst_o are all 0;
  - mem_addr_o, mem_data_o, word_count_o and the byte-lane counter are all 0.
  - Reset mid-load aborts immediately; memory contents are then undefined until the next full load.
- All outputs are registered.
- A byte is accepted at an edge where byte_valid_i & byte_ready_o. byte_ready_o=1 only in LOAD.
- IDLE:
  - CPU is held in reset (cpu_rst_o=0).
  - start_i=1 → CLEAR, with address 0.
- CLEAR:
  - Each cycle: mem_we_o=1, mem_data_o=0, mem_addr_o=k for k=0..DEPTH-1. That is exactly DEPTH write cycles.
  - The edge ending the k=DEPTH-1 write → LOAD, with address 0, lane 0, word_count_o=0, overflow_o=0.
  - start_i is ignored.
- LOAD:
  - Accepted byte at lane L (0..3) goes into bits [8L+7:8L] of the assembly register; L then increments modulo 4.
  - On acceptance of a lane-3 byte:
    - next cycle mem_we_o=1, mem_data_o = assembled word, mem_addr_o = word_count_o;
    - word_count_o increments at that write's edge;
    - the assembly register clears.
  - Back-to-back full words give one write every 4 accepted bytes. The write latency is 1 cycle after the 4th byte.
  - Last byte accepted at lane L<3: the next cycle writes the partial word with upper lanes zero-padded, then the state goes to FLUSH.
  - Last byte accepted at lane 3: the word is written normally, then the state goes to FLUSH.
  - Overflow: once word_count_o==DEPTH, further bytes are still accepted (byte_ready_o stays 1) but discarded with no write, and overflow_o=1. byte_last_i still ends the load.
  - start_i is ignored.
  - No accepted bytes → the loader stays in LOAD indefinitely.
- FLUSH:
  - Lasts one cycle and covers the final write (mem_we_o=1).
  - byte_ready_o=0.
  - → DONE.
- DONE:
  - done_o=1 and cpu_rst_o=1, both set from the edge after the final write.
  - word_count_o and overflow_o hold their values.
  - start_i=1 → CLEAR: cpu_rst_o=0, done_o=0, and the CPU is re-held in reset for the new load.
- mem_we_o is never high outside CLEAR, LOAD (1 cycle after a word completes) and FLUSH.

Test Plan:
- Reset only, start_i=0 for 10 cycles → cpu_rst_o=0, mem_we_o=0, byte_ready_o=0, done_o=0, busy_o=0.
- start_i pulse (DEPTH=256) → exactly 256 consecutive writes, addresses 0..255, data 0, byte_ready_o=0 throughout. byte_valid_i held high during CLEAR → no byte is consumed.
- Stream 13 05 50 00 93 05 60 00 (last on the 8th byte), valid every cycle:
  - addr0=0x00500513, one cycle after the 4th byte;
  - addr1=0x00600593;
  - word_count_o=2;
  - done_o=cpu_rst_o=1 two cycles after the 8th byte.
- Stream EF BE AD DE AB (last on AB), with byte_valid_i gaps of 0–3 cycles → addr0=0xDEADBEEF, addr1=0x000000AB, word_count_o=2, overflow_o=0.
- DEPTH=4, 20 bytes (last on 20th) → 4 data writes at addr0..3, no 5th write, overflow_o=1, done_o=1. Then start_i → cpu_rst_o=0, CLEAR again, overflow_o=0 on entering LOAD.
- rst_i=1 after 6 bytes of a load → next cycle IDLE, all outputs at reset values. A new start_i then completes a full clear+load correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: zero-clears the imem, packs a little-endian byte
// stream into 32-bit words, then releases the CPU from reset.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             load request (honoured in IDLE or DONE)
//   byte_valid_i/data/last, byte_ready_o   byte stream handshake
//   mem_we_o/addr_o/data_o                 imem write port
//   cpu_rst_o           CPU reset, active low (1 = run)
//   busy_o, done_o      status
//   word_count_o        words written from the stream this load
//   overflow_o          sticky, bytes arrived after DEPTH words
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              overflow_o
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       data_d;
    logic              we_d, ready_d, cpu_rst_d, busy_d, done_d, ovf_d;
    logic [ADDR_W:0]   wc_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       word_n;

    always_comb begin
        state_d   = state_q;
        addr_d    = mem_addr_o;
        data_d    = mem_data_o;
        we_d      = 1'b0;
        ready_d   = byte_ready_o;
        cpu_rst_d = cpu_rst_o;
        busy_d    = busy_o;
        done_d    = done_o;
        ovf_d     = overflow_o;
        wc_d      = word_count_o;
        lane_d    = lane_q;
        asm_d     = asm_q;
        word_n    = asm_q | (32'(byte_data_i) << {lane_q, 3'b000});

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = CLEAR;
                    we_d      = 1'b1;
                    addr_d    = '0;
                    data_d    = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    cpu_rst_d = 1'b0;
                end
            end
            CLEAR: begin
                if (mem_addr_o == LAST_ADDR) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    lane_d  = '0;
                    asm_d   = '0;
                    wc_d    = '0;
                    ovf_d   = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = mem_addr_o + 1'b1;
                    data_d = '0;
                end
            end
            LOAD: begin
                if (byte_valid_i && byte_ready_o) begin
                    lane_d = lane_q + 2'd1;
                    if (word_count_o == FULL_CNT) begin
                        // Memory full: keep draining the stream, drop bytes.
                        ovf_d = 1'b1;
                        asm_d = '0;
                    end else if (lane_q == 2'd3 || byte_last_i) begin
                        // Count is bumped together with scheduling the write
                        // so the full check sees it on the very next byte.
                        we_d   = 1'b1;
                        data_d = word_n;
                        addr_d = word_count_o[ADDR_W-1:0];
                        wc_d   = word_count_o + 1'b1;
                        asm_d  = '0;
                        lane_d = '0;
                    end else begin
                        asm_d = word_n;
                    end
                    if (byte_last_i) begin
                        state_d = FLUSH;
                        ready_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                state_d   = DONE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                cpu_rst_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_we_o     <= 1'b0;
            byte_ready_o <= 1'b0;
            cpu_rst_o    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            overflow_o   <= 1'b0;
            word_count_o <= '0;
            lane_q       <= '0;
            asm_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_o   <= addr_d;
            mem_data_o   <= data_d;
            mem_we_o     <= we_d;
            byte_ready_o <= ready_d;
            cpu_rst_o    <= cpu_rst_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            overflow_o   <= ovf_d;
            word_count_o <= wc_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
        end
    end

endmodule
